// File: rtl/reg_spill.sv
// reg_spill: register save/restore engine.
// Pushes a, b, c, d (plus ix, iy when REG_SPILL_IDX_EN is defined) below sp
// through one regfile read port and one memory port, or pops them back
// through one regfile write port, then writes the updated sp.
//
// Build option: REG_SPILL_IDX_EN -- include ix (5) and iy (6) in the set.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_save / start_restore (save wins a tie)
// SP_RD  | read sp from the regfile into ptr
// RD     | save: read register k, pre-decrement ptr
// WR     | save: write register k to mem[ptr], hold until ack
// MEM    | restore: read mem[ptr], hold until ack, capture data
// WB     | restore: write captured data to register k, post-increment ptr
// SP_WB  | write ptr back to sp
// DONE   | one-cycle completion pulse, starts ignored

module reg_spill #(
  parameter logic [3:0]  SP_SEL    = 4'b0111,
  parameter logic [15:0] WORD_STEP = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_save,
  input  logic        start_restore,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rf_out_sel,
  input  logic [15:0] rf_out_data,
  output logic [3:0]  rf_in_sel,
  output logic [15:0] rf_in_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

`ifdef REG_SPILL_IDX_EN
  localparam logic [2:0] NREG = 3'd6;
`else
  localparam logic [2:0] NREG = 3'd4;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SP_RD = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_SP_WB = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        op_rest;
  logic [2:0]  remain;
  logic [15:0] ptr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [3:0]  cur_sel;
  logic        last;
  logic        xfer;

  // Register select for the current slot: save walks a upward, restore walks
  // from the last register down to a, both driven by the same down-counter.
  always_comb begin
    cur_sel = 4'd0;
    if (op_rest) begin
      cur_sel = {1'b0, remain};
    end else begin
      cur_sel = {1'b0, NREG} + 4'd1 - {1'b0, remain};
    end
  end

  assign last = (remain == 3'd1);
  assign xfer = mem_req && mem_ack;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_save || start_restore) begin
          state_nxt = S_SP_RD;
        end
      end
      S_SP_RD: begin
        state_nxt = op_rest ? S_MEM : S_RD;
      end
      S_RD: begin
        state_nxt = S_WR;
      end
      S_WR: begin
        if (mem_ack) begin
          state_nxt = last ? S_SP_WB : S_RD;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        state_nxt = last ? S_SP_WB : S_MEM;
      end
      S_SP_WB: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and operation direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_rest <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && (start_save || start_restore)) begin
        op_rest <= !start_save;
      end
    end
  end

  // Slot down-counter: loaded with the register count, terminal at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain <= 3'd0;
    end else if (state == S_SP_RD) begin
      remain <= NREG;
    end else if ((state == S_WR && mem_ack) || state == S_WB) begin
      remain <= remain - 3'd1;
    end
  end

  // Stack pointer working copy: pre-decrement on push, post-increment on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 16'd0;
    end else begin
      case (state)
        S_SP_RD: ptr <= rf_out_data;
        S_RD:    ptr <= ptr - WORD_STEP;
        S_WB:    ptr <= ptr + WORD_STEP;
        default: ptr <= ptr;
      endcase
    end
  end

  // Data holding registers for the write and read paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata <= 16'd0;
      rdata <= 16'd0;
    end else begin
      if (state == S_RD) begin
        wdata <= rf_out_data;
      end
      if (state == S_MEM && xfer) begin
        rdata <= mem_rdata;
      end
    end
  end

  // Output decode purely from registered state, so reset clears it at once.
  always_comb begin
    busy       = (state != S_IDLE) && (state != S_DONE);
    done       = (state == S_DONE);
    rf_out_sel = 4'd0;
    rf_in_sel  = 4'd0;
    rf_in_data = 16'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'd0;
    mem_wdata  = 16'd0;
    case (state)
      S_SP_RD: rf_out_sel = SP_SEL;
      S_RD:    rf_out_sel = cur_sel;
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = wdata;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = ptr;
      end
      S_WB: begin
        rf_in_sel  = cur_sel;
        rf_in_data = rdata;
      end
      S_SP_WB: begin
        rf_in_sel  = SP_SEL;
        rf_in_data = ptr;
      end
      default: begin
        rf_out_sel = 4'd0;
      end
    endcase
  end

`ifndef SYNTHESIS
  // A pending memory request must not change until it is acknowledged.
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

  // Never write the regfile and access memory in the same cycle.
  a_excl: assert property (@(posedge clk) disable iff (rst)
    !(mem_req && (rf_in_sel != 4'd0)));
`endif

endmodule

// File: tb/tb_reg_spill.sv
// Scoreboard bench for reg_spill: stimulus queues expected memory accesses,
// regfile writes and done latencies; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_reg_spill;
`ifdef REG_SPILL_IDX_EN
  localparam int N = 6;
`else
  localparam int N = 4;
`endif
  localparam logic [3:0] SP = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_save = 1'b0;
  logic        start_restore = 1'b0;
  logic        busy, done;
  logic [3:0]  rf_out_sel, rf_in_sel;
  logic [15:0] rf_out_data, rf_in_data;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  reg_spill dut (
    .clk(clk), .rst(rst), .start_save(start_save), .start_restore(start_restore),
    .busy(busy), .done(done), .rf_out_sel(rf_out_sel), .rf_out_data(rf_out_data),
    .rf_in_sel(rf_in_sel), .rf_in_data(rf_in_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [0:15];
  logic [15:0] mem [0:65535];
  logic        tb_wr = 1'b0;
  logic [3:0]  tb_sel = 4'd0;
  logic [15:0] tb_data = 16'd0;
  int wait_n = 0;
  int wcnt;
  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int failures = 0;

  assign rf_out_data = rf[rf_out_sel];
  assign mem_rdata   = mem[mem_addr];
  assign mem_ack     = mem_req && (wcnt >= wait_n);

  // Regfile and memory models (single writer process).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_wr) rf[tb_sel] <= tb_data;
    else if (rf_in_sel != 4'd0) rf[rf_in_sel] <= rf_in_data;
    if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Wait-state counter for delayed acknowledges.
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (mem_req && mem_ack) wcnt <= 0;
    else if (mem_req) wcnt <= wcnt + 1;
  end

  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } mem_t;
  typedef struct { logic [3:0] sel; logic [15:0] data; } rfw_t;
  mem_t exp_mem[$];
  rfw_t exp_rf[$];
  int   exp_done[$];

  function automatic logic [15:0] val(input int k);
    return 16'(16'h1111 * k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  logic        stall_v = 1'b0;
  logic [15:0] s_addr, s_wdata;
  logic        s_we;

  // Monitor: compares every DUT transfer against the scoreboard queues.
  always @(negedge clk) begin
    mem_t em;
    rfw_t er;
    int   ed;
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        chk("hold_req", {31'd0, mem_req}, 32'd1);
        chk("hold_addr", {16'd0, mem_addr}, {16'd0, s_addr});
        chk("hold_we", {31'd0, mem_we}, {31'd0, s_we});
        chk("hold_wdata", {16'd0, mem_wdata}, {16'd0, s_wdata});
      end
      stall_v = mem_req && !mem_ack;
      s_addr  = mem_addr;
      s_we    = mem_we;
      s_wdata = mem_wdata;
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) unexpected("mem_access", {15'd0, mem_we, mem_addr});
        else begin
          em = exp_mem.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, em.we});
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, em.addr});
          if (em.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, em.data});
        end
      end
      if (rf_in_sel != 4'd0) begin
        if (exp_rf.size() == 0) unexpected("rf_write", {12'd0, rf_in_sel, rf_in_data});
        else begin
          er = exp_rf.pop_front();
          chk("rf_sel", {28'd0, rf_in_sel}, {28'd0, er.sel});
          chk("rf_data", {16'd0, rf_in_data}, {16'd0, er.data});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done", 32'(cyc - t0));
        else begin
          ed = exp_done.pop_front();
          chk("done_cycle", 32'(cyc - t0), 32'(ed));
        end
      end
    end
  end

  task automatic set_reg(input logic [3:0] s, input logic [15:0] v);
    @(negedge clk);
    tb_wr = 1'b1; tb_sel = s; tb_data = v;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic r);
    @(negedge clk);
    start_save = s; start_restore = r; t0 = cyc;
    @(negedge clk);
    start_save = 1'b0; start_restore = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  task automatic push_save(input logic [15:0] sp);
    mem_t m;
    rfw_t r;
    for (int k = 1; k <= N; k++) begin
      m.we = 1'b1; m.addr = 16'(sp - 16'(k)); m.data = val(k);
      exp_mem.push_back(m);
    end
    r.sel = SP; r.data = 16'(sp - 16'(N));
    exp_rf.push_back(r);
    exp_done.push_back(2 * N + 3 + wait_n * N);
  endtask

  task automatic push_restore(input logic [15:0] sp);
    mem_t m;
    rfw_t r;
    for (int j = 0; j < N; j++) begin
      m.we = 1'b0; m.addr = 16'(sp + 16'(j)); m.data = 16'd0;
      exp_mem.push_back(m);
      r.sel = 4'(N - j); r.data = val(N - j);
      exp_rf.push_back(r);
    end
    r.sel = SP; r.data = 16'(sp + 16'(N));
    exp_rf.push_back(r);
    exp_done.push_back(2 * N + 3 + wait_n * N);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_out_sel", {28'd0, rf_out_sel}, 32'd0);
    chk("rst_in_sel", {28'd0, rf_in_sel}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_in_data", {16'd0, rf_in_data}, 32'd0);
    rst = 1'b0;

    for (int k = 1; k <= 6; k++) set_reg(4'(k), val(k));

    // Save, zero-wait, sp=0x0100
    set_reg(SP, 16'h0100);
    push_save(16'h0100);
    pulse(1'b1, 1'b0);
    wait_done("save");
    @(negedge clk);
    chk("save_sp", {16'd0, rf[SP]}, {16'd0, 16'(16'h0100 - 16'(N))});
    for (int k = 1; k <= N; k++)
      chk("save_mem", {16'd0, mem[16'(16'h0100 - 16'(k))]}, {16'd0, val(k)});

    // Restore into cleared registers
    for (int k = 1; k <= 6; k++) set_reg(4'(k), 16'd0);
    set_reg(SP, 16'(16'h0100 - 16'(N)));
    push_restore(16'(16'h0100 - 16'(N)));
    pulse(1'b0, 1'b1);
    wait_done("restore");
    @(negedge clk);
    chk("restore_sp", {16'd0, rf[SP]}, 32'h0100);
    for (int k = 1; k <= 6; k++)
      chk("restore_reg", {16'd0, rf[k]}, {16'd0, (k <= N) ? val(k) : 16'd0});
    for (int k = N + 1; k <= 6; k++) set_reg(4'(k), val(k));

    // Save with three wait states per access
    wait_n = 3;
    set_reg(SP, 16'h0100);
    push_save(16'h0100);
    pulse(1'b1, 1'b0);
    wait_done("wait_save");
    wait_n = 0;
    @(negedge clk);
    chk("wait_sp", {16'd0, rf[SP]}, {16'd0, 16'(16'h0100 - 16'(N))});

    // Address wrap below zero
    set_reg(SP, 16'h0002);
    push_save(16'h0002);
    pulse(1'b1, 1'b0);
    wait_done("wrap");
    @(negedge clk);
    chk("wrap_sp", {16'd0, rf[SP]}, {16'd0, 16'(16'h0002 - 16'(N))});
    chk("wrap_mem_ffff", {16'd0, mem[16'hFFFF]}, {16'd0, val(3)});

    // Both starts together: save wins; starts while busy or in DONE ignored
    set_reg(SP, 16'h0300);
    push_save(16'h0300);
    pulse(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    start_restore = 1'b1;
    @(negedge clk);
    start_restore = 1'b0;
    wait_done("both");
    start_restore = 1'b1;
    @(negedge clk);
    start_restore = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignore_busy", {31'd0, busy}, 32'd0);
    chk("ignore_req", {31'd0, mem_req}, 32'd0);
    chk("ignore_sp", {16'd0, rf[SP]}, {16'd0, 16'(16'h0300 - 16'(N))});

    // Reset during the third write of a save
    set_reg(SP, 16'h0100);
    wait_n = 3;
    exp_mem.push_back('{1'b1, 16'h00FF, val(1)});
    exp_mem.push_back('{1'b1, 16'h00FE, val(2)});
    pulse(1'b1, 1'b0);
    n = 0;
    while (!(mem_req && mem_addr == 16'h00FD) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_wr3", {31'd0, mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_req", {31'd0, mem_req}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_in_sel", {28'd0, rf_in_sel}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_n = 0;
    chk("mid_sp", {16'd0, rf[SP]}, 32'h0100);
    push_save(16'h0100);
    pulse(1'b1, 1'b0);
    wait_done("post_reset");
    @(negedge clk);
    chk("post_reset_sp", {16'd0, rf[SP]}, {16'd0, 16'(16'h0100 - 16'(N))});

    repeat (3) @(negedge clk);
    chk("left_mem", 32'(exp_mem.size()), 32'd0);
    chk("left_rf", 32'(exp_rf.size()), 32'd0);
    chk("left_done", 32'(exp_done.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
